// File: rtl/vram_scan.sv
// Z88 frame-buffer scan-out: VGA-style timing generator, VRAM nibble fetch
// and 4-bit pixel serialiser. Every Z88 line is shown LINE_REP times.
module vram_scan #(
  parameter int H_VIS    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_VIS    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_TOP    = 16,
  parameter int LINE_REP = 7
) (
  input  logic        mck,
  input  logic        rin,
  input  logic        pix_ce,
  input  logic        lcdon,
  output logic [13:0] vram_ra,
  input  logic [3:0]  vram_di,
  output logic        pix,
  output logic        de,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        sof
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST    = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_L   = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L   = 10'(V_VIS);
  localparam logic [9:0] HS_BEG    = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG    = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] Z_BEG     = 10'(V_TOP);
  localparam logic [9:0] Z_END     = 10'(V_TOP + 64 * LINE_REP);
  localparam logic [9:0] FETCH_LIM = 10'(H_VIS - 4);
  localparam logic [9:0] EOL_FETCH = 10'(H_TOT - 3);
  localparam logic [2:0] REP_LAST  = 3'(LINE_REP - 1);

  logic [9:0] hcnt, vcnt;
  logic [9:0] h_nx, v_nx, v_line_nx;
  logic       h_wrap, v_wrap;
  logic       in_z, z_nx, de_nx, hs_nx, vs_nx;
  logic [5:0] zline, zl_line_nx;
  logic [2:0] rep, rep_line_nx;
  logic [3:0] sh, hold, sh_nx;
  logic       sh_load, fetch_pend, fetch_mid, fetch_eol;

  // Counter successors: h_nx/v_nx are the position entered on this pix_ce edge.
  always_comb begin
    h_wrap    = (hcnt == H_LAST);
    v_wrap    = (vcnt == V_LAST);
    h_nx      = h_wrap ? 10'd0 : hcnt + 10'd1;
    v_line_nx = v_wrap ? 10'd0 : vcnt + 10'd1;
    v_nx      = h_wrap ? v_line_nx : vcnt;
  end

  // zline/rep as they will be once the line advances; the end-of-line
  // fetch needs this before the wrap actually happens.
  always_comb begin
    in_z        = (vcnt >= Z_BEG) && (vcnt < Z_END);
    zl_line_nx  = zline;
    rep_line_nx = rep;
    if (v_line_nx == Z_BEG) begin
      zl_line_nx  = 6'd0;
      rep_line_nx = 3'd0;
    end else if (in_z) begin
      if (rep == REP_LAST) begin
        rep_line_nx = 3'd0;
        zl_line_nx  = zline + 6'd1;
      end else begin
        rep_line_nx = rep + 3'd1;
      end
    end
  end

  always_comb begin
    z_nx      = (v_nx >= Z_BEG) && (v_nx < Z_END);
    de_nx     = (h_nx < H_VIS_L) && (v_nx < V_VIS_L);
    hs_nx     = !((h_nx >= HS_BEG) && (h_nx < HS_END));
    vs_nx     = !((v_nx >= VS_BEG) && (v_nx < VS_END));
    fetch_mid = (h_nx[1:0] == 2'd1) && (h_nx < FETCH_LIM);
    fetch_eol = (h_nx == EOL_FETCH);
    sh_load   = (hcnt[1:0] == 2'd3) || h_wrap;
    sh_nx     = sh_load ? hold : {sh[2:0], 1'b0};
  end

  // Handshake: pix_ce qualifies every state change. vram_ra is registered;
  // vram_di must be valid by the following mck edge and is captured into
  // hold on the next pix_ce edge after the address was issued.
  always_ff @(posedge mck) begin
    if (rin) begin
      hcnt       <= 10'd0;
      vcnt       <= 10'd0;
      zline      <= 6'd0;
      rep        <= 3'd0;
      sh         <= 4'd0;
      hold       <= 4'd0;
      fetch_pend <= 1'b0;
      vram_ra    <= 14'd0;
      pix        <= 1'b0;
      de         <= 1'b0;
      hsync_n    <= 1'b1;
      vsync_n    <= 1'b1;
      sof        <= 1'b0;
    end else begin
      sof <= pix_ce && h_wrap && v_wrap;
      if (pix_ce) begin
        hcnt <= h_nx;
        vcnt <= v_nx;
        if (h_wrap) begin
          zline <= zl_line_nx;
          rep   <= rep_line_nx;
        end
        sh <= sh_nx;
        if (fetch_pend) hold <= vram_di;
        fetch_pend <= fetch_mid || fetch_eol;
        if (fetch_mid) begin
          vram_ra <= {zline, h_nx[9:2] + 8'd1};
        end else if (fetch_eol) begin
          vram_ra <= {zl_line_nx, 8'd0};
        end
        de      <= de_nx;
        hsync_n <= hs_nx;
        vsync_n <= vs_nx;
        pix     <= sh_nx[3] && de_nx && lcdon && z_nx;
      end
    end
  end

endmodule

// File: tb/tb_vram_scan.sv
// Bench for vram_scan with shrunk timing parameters: a position/frame model
// predicts every output per pix_ce edge; a monitor pops and compares.
module tb_vram_scan;

  localparam int H_VIS    = 32;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 4;
  localparam int V_VIS    = 134;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int V_TOP    = 3;
  localparam int LINE_REP = 2;
  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;

  logic        mck = 1'b0;
  logic        rin, pix_ce, lcdon;
  logic [13:0] vram_ra;
  logic [3:0]  vram_di = 4'd0;
  logic        pix, de, hsync_n, vsync_n, sof;

  logic [3:0]  vram [0:16383];
  logic [38:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          mh, mv;
  logic [13:0] m_ra;
  int          sof_exp = 0;
  int          sof_seen = 0;

  vram_scan #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .V_TOP(V_TOP), .LINE_REP(LINE_REP)
  ) dut (
    .mck(mck), .rin(rin), .pix_ce(pix_ce), .lcdon(lcdon),
    .vram_ra(vram_ra), .vram_di(vram_di),
    .pix(pix), .de(de), .hsync_n(hsync_n), .vsync_n(vsync_n), .sof(sof)
  );

  // clock / reset block
  initial forever #5 mck = ~mck;

  // VRAM read port: data follows the address half a cycle later, so it is
  // only usable on the mck edge after the address changed.
  always @(negedge mck) vram_di = vram[vram_ra];

  function automatic bit in_z(input int v);
    return (v >= V_TOP) && (v < V_TOP + 64 * LINE_REP);
  endfunction

  function automatic int zl(input int v);
    if (in_z(v)) return (v - V_TOP) / LINE_REP;
    return 0;
  endfunction

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got ra=%h pix/de/hs/vs/sof=%b expected ra=%h pix/de/hs/vs/sof=%b",
               name, got[18:5], got[4:0], want[18:5], want[4:0]);
    end
  endtask

  // Reference model: advance the screen position one pixel and derive the
  // outputs straight from the frame geometry and VRAM contents.
  task automatic model_step(input logic lc);
    logic [5:0] z;
    logic [7:0] n;
    logic [3:0] d;
    logic p, e, hs, vs, sf;
    mh++;
    if (mh == H_TOT) begin
      mh = 0;
      mv = (mv + 1) % V_TOT;
    end
    sf = (mh == 0) && (mv == 0);
    if ((mh % 4 == 1) && (mh / 4 + 1 < H_VIS / 4)) begin
      z = 6'(zl(mv));
      n = 8'(mh / 4 + 1);
      m_ra = {z, n};
    end else if (mh == H_TOT - 3) begin
      z = 6'(zl((mv + 1) % V_TOT));
      m_ra = {z, 8'd0};
    end
    e  = (mh < H_VIS) && (mv < V_VIS);
    hs = !((mh >= H_VIS + H_FP) && (mh < H_VIS + H_FP + H_SYNC));
    vs = !((mv >= V_VIS + V_FP) && (mv < V_VIS + V_FP + V_SYNC));
    z  = 6'(zl(mv));
    n  = 8'(mh / 4);
    d  = vram[{z, n}];
    p  = e && lc && in_z(mv) && d[3 - (mh % 4)];
    if (sf) sof_exp++;
    exp_q.push_back({10'(mv), 10'(mh), m_ra, p, e, hs, vs, sf});
  endtask

  // driver tasks
  task automatic step(input logic ce, input logic lc);
    @(negedge mck);
    rin    = 1'b0;
    pix_ce = ce;
    lcdon  = lc;
    if (ce) model_step(lc);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge mck);
      rin    = 1'b1;
      pix_ce = 1'($urandom_range(0, 1));
      lcdon  = 1'($urandom_range(0, 1));
    end
    mh   = 0;
    mv   = 0;
    m_ra = 14'd0;
  endtask

  // scoreboard monitor
  always @(posedge mck) begin
    logic r, c;
    logic [38:0] e;
    r = rin;
    c = pix_ce;
    #1;
    if (sof === 1'b1) sof_seen++;
    if (r) begin
      check("reset", {vram_ra, pix, de, hsync_n, vsync_n, sof}, {14'd0, 5'b00110});
    end else if (c) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue_empty got output with no expectation queued, required a queued entry");
      end else begin
        e = exp_q.pop_front();
        check($sformatf("out_v%0d_h%0d", e[38:29], e[28:19]),
              {vram_ra, pix, de, hsync_n, vsync_n, sof}, e[18:0]);
      end
    end else begin
      total++;
      if (sof !== 1'b0) begin
        bad++;
        $display("FAIL sof_idle got sof=%b required 0", sof);
      end
    end
  end

  initial begin
    int  n, cnt;
    bit  seen, ce;
    rin    = 1'b1;
    pix_ce = 1'b0;
    lcdon  = 1'b1;
    for (int i = 0; i < 16384; i++) vram[i] = 4'($urandom_range(0, 15));
    vram[0] = 4'hA;
    vram[H_VIS / 4 - 1] = 4'h1;

    do_reset(3);

    // hsync falls H_VIS+H_FP pixels after reset release
    n = 0;
    seen = 0;
    for (int i = 0; i < 2 * H_TOT && !seen; i++) begin
      step(1'b1, 1'b1);
      @(posedge mck);
      #2;
      n++;
      if (hsync_n === 1'b0) seen = 1;
    end
    total++;
    if (!seen || n != H_VIS + H_FP) begin
      bad++;
      $display("FAIL hsync_first got %0d pixels (seen=%0d) required %0d", n, seen, H_VIS + H_FP);
    end

    // continuous pix_ce: one full frame, then stop mid-frame and reset
    for (int i = 0; i < 3 * H_TOT * V_TOT && !(sof_exp >= 1 && mh == 30 && mv == 20); i++)
      step(1'b1, 1'b1);
    do_reset(2);

    // pix_ce toggling 1/0 for two frames
    for (int i = 0; i < 2 * (H_TOT * V_TOT + 2 * H_TOT); i++)
      step(i % 2 == 0, 1'b1);

    // lcdon off for a full frame with random pix_ce gaps
    cnt = 0;
    while (cnt < H_TOT * V_TOT) begin
      ce = ($urandom_range(0, 3) != 0);
      step(ce, 1'b0);
      if (ce) cnt++;
    end

    // lcdon toggling randomly pixel by pixel
    cnt = 0;
    while (cnt < H_TOT * V_TOT) begin
      ce = ($urandom_range(0, 3) != 0);
      step(ce, 1'($urandom_range(0, 1)));
      if (ce) cnt++;
    end

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    @(posedge mck);
    #3;

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_left got %0d pending entries required 0", exp_q.size());
    end
    total++;
    if (sof_seen != sof_exp) begin
      bad++;
      $display("FAIL sof_count got %0d pulses required %0d", sof_seen, sof_exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout got no completion required finish before time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_scan.md
# vram_scan

Display scan-out engine for the Z88 frame buffer. The screen renderer writes 4-pixel nibbles into VRAM at `{line[5:0], nibble[7:0]}`; this block is the reader at the other end of that buffer. It generates 640x480@60 VGA-style timing, fetches nibbles through the VRAM read port, and serialises them to a 1-bit pixel stream. Each of the 64 Z88 lines is repeated 7 times, with a 16-line border above and below.

## Interface

Parameters:
- `H_VIS` 640: visible pixels per line.
- `H_FP` 16: horizontal front porch.
- `H_SYNC` 96: hsync width.
- `H_BP` 48: horizontal back porch (h total 800).
- `V_VIS` 480: visible lines.
- `V_FP` 10: vertical front porch.
- `V_SYNC` 2: vsync width.
- `V_BP` 33: vertical back porch (v total 525).
- `V_TOP` 16: border lines before Z88 line 0.
- `LINE_REP` 7: output lines per Z88 line.

Ports:
- `mck` in 1: system clock.
- `rin` in 1: synchronous reset, active-high.
- `pix_ce` in 1: pixel clock enable; one pixel per `mck` cycle with `pix_ce`=1.
- `lcdon` in 1: display enable; 0 blanks pixels, timing keeps running.
- `vram_ra` out 14: VRAM read address `{zline[5:0], nib[7:0]}`.
- `vram_di` in 4: VRAM read data, valid one `mck` after `vram_ra` changes.
- `pix` out 1: pixel, 1 = lit.
- `de` out 1: data enable (visible area).
- `hsync_n` out 1: hsync, active-low.
- `vsync_n` out 1: vsync, active-low.
- `sof` out 1: start-of-frame pulse, one `mck` wide.

## Operation

- All state advances only on `mck` edges with `pix_ce`=1, except `sof`, which drops on the next `mck` edge.
- Counters:
  - `hcnt` counts 0..799 and wraps to 0.
  - `vcnt` advances when `hcnt` wraps, counting 0..524 and wrapping to 0.
- Sync and enable:
  - `hsync_n`=0 for `hcnt` 656..751.
  - `vsync_n`=0 for `vcnt` 490..491.
  - `de`=1 when `hcnt`<640 and `vcnt`<480.
- Vertical mapping:
  - Z88 region is `vcnt` 16..463.
  - `zline` (6 bits) and sub-counter `rep` (0..6) reset to 0 at `vcnt`=16.
  - `rep` increments per line; at `rep`=6 it wraps to 0 and `zline` increments.
  - No divider is used.
  - `vcnt` 0..15 and 464..479 are border: `pix`=0.
- Nibble index `nib` = `hcnt[9:2]`, 0..159. Nibble values 160..255 are never addressed.
- Pixel order: `vram_di[3]` is the leftmost pixel.
- Shifter operation:
  - A 4-bit shifter shifts left one place per pixel and drives `pix` from `sh[3]`.
  - It loads the holding register on the edge where `hcnt[1:0]`=3, and on the `hcnt`=799→0 edge.
- Fetch pipeline for nibble k+1 (k = 0..158):
  - `vram_ra` is set on the edge entering `hcnt`=4k+1.
  - `vram_di` is captured into the holding register on the next `pix_ce` edge.
- Fetch for nibble 0 of the next line:
  - `vram_ra` = `{next zline, 0}` is set on the edge entering `hcnt`=797.
  - Data is captured at 798 and loaded at 799→0.
  - "Next zline" is the `zline` in effect after the `vcnt` advance.
- `pix` = `sh[3] & de & lcdon & in_zregion`.
- `sof` pulses on the edge where `vcnt` and `hcnt` both wrap to 0.
- `vram_ra` holds its last value outside fetch edges. Read-port accesses have no side effects.

## Timing

- Outputs are registered.
  - `de`, `hsync_n`, `vsync_n` and `pix` reflect the counter value entered on the same edge, with no extra pipeline stage.
  - Pixel at `hcnt`=h appears on the edge entering h.
- VRAM read latency tolerated: exactly 1 `mck`. `pix_ce` may be high every cycle.
- Reset (`rin`=1 on an `mck` edge, regardless of `pix_ce`):
  - `hcnt`=`vcnt`=0, `zline`=`rep`=0, `sh`=0, holding register=0.
  - `vram_ra`=0, `pix`=0, `de`=0, `hsync_n`=1, `vsync_n`=1, `sof`=0.
  - After release, the first frame starts from `vcnt`=0. The first visible line after reset may show stale nibble 0 (border line, masked).
- Reset mid-line or mid-frame aborts immediately; no partial sync pulse is extended.
- `lcdon` toggling mid-line takes effect on the next pixel. Counters are unaffected.
- `pix_ce`=0 freezes all state and outputs except `sof` clear.

## Test plan

- Reset: assert `rin` mid-frame (`hcnt`=300, `vcnt`=200) → all outputs at reset values next edge. Release → `hsync_n` first falls 656 `pix_ce`s later.
- Sync timing, `pix_ce`=1 constantly:
  - `hsync_n` low for exactly 96 cycles, period 800.
  - `vsync_n` low for exactly 1600 cycles, period 420000.
  - `sof` one cycle per 420000.
- Pixel order: VRAM line 0 nibble 0 = 0xA, nibble 159 = 0x1 → at `vcnt`=16:
  - `pix` at `hcnt` 0..3 = 1,0,1,0.
  - `pix` at `hcnt` 636..639 = 0,0,0,1.
  - `pix`=0 at `hcnt`≥640.
- Line repetition: distinct pattern per Z88 line:
  - `vcnt` 16..22 show line 0, 23..29 show line 1, 457..463 show line 63.
  - `vcnt` 0..15 and 464..479 `pix`=0 with `de`=1.
- Fetch sequence: `pix_ce` toggling 1/0 → `vram_ra` low byte steps 1,2,…,159 at `hcnt`≡1 mod 4, then 0 at 797. Pixel stream identical to the `pix_ce`=1 run.
- `lcdon`=0 for one full frame → `pix`=0 throughout; `de`/sync unchanged. Restore → pixels resume on the next pixel.
